// File: rtl/fp_add_arbiter.sv
// Two-requester front end for a shared single-precision adder.
// Round-robin grant, special-operand bypass, adder timeout, held response.
module fp_add_arbiter #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [63:0] req_a,
  input  logic [63:0] req_b,
  output logic [1:0]  resp_valid,
  input  logic [1:0]  resp_ready,
  output logic [31:0] resp_result,
  output logic [2:0]  resp_err,
  output logic        add_start,
  output logic [31:0] add_a,
  output logic [31:0] add_b,
  input  logic        add_done,
  input  logic [31:0] add_result,
  input  logic [2:0]  add_err,
  output logic        busy
);

  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] TLAST = CW'(TIMEOUT - 1);

  localparam logic [2:0]  ERR_NONE    = 3'd0;
  localparam logic [2:0]  ERR_INVALID = 3'd1;
  localparam logic [31:0] QNAN        = 32'h7FFFFFFF;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t        state, state_n;
  logic          rr;
  logic          g;
  logic [CW-1:0] cnt;

  logic          gnt_any;
  logic          gnt;
  logic          accept;
  logic [31:0]   sel_a, sel_b;
  logic          nan_a, nan_b, inf_a, inf_b;
  logic          invalid, inf_any;
  logic          timeout_hit;

  function automatic logic is_nan(input logic [31:0] x);
    return (&x[30:23]) && (|x[22:0]);
  endfunction

  function automatic logic is_inf(input logic [31:0] x);
    return (&x[30:23]) && !(|x[22:0]);
  endfunction

  // A lone requester always wins; the pointer only breaks ties.
  assign gnt_any = |req_valid;
  assign gnt     = (req_valid == 2'b10) ? 1'b1 :
                   (req_valid == 2'b01) ? 1'b0 : rr;

  assign sel_a = gnt ? req_a[63:32] : req_a[31:0];
  assign sel_b = gnt ? req_b[63:32] : req_b[31:0];

  assign nan_a   = is_nan(sel_a);
  assign nan_b   = is_nan(sel_b);
  assign inf_a   = is_inf(sel_a);
  assign inf_b   = is_inf(sel_b);
  assign invalid = nan_a || nan_b || (inf_a && inf_b && (sel_a[31] ^ sel_b[31]));
  assign inf_any = inf_a || inf_b;

  // add_done wins over expiry because it is tested first in both processes.
  assign timeout_hit = (cnt == TLAST);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n    = state;
    req_ready  = '0;
    resp_valid = '0;
    add_start  = 1'b0;
    accept     = 1'b0;
    case (state)
      S_IDLE: begin
        if (gnt_any) begin
          req_ready[gnt] = 1'b1;
          accept         = 1'b1;
          state_n        = (invalid || inf_any) ? S_RESP : S_ISSUE;
        end
      end
      S_ISSUE: begin
        add_start = 1'b1;
        state_n   = S_WAIT;
      end
      S_WAIT: begin
        if (add_done || timeout_hit) state_n = S_RESP;
      end
      S_RESP: begin
        resp_valid[g] = 1'b1;
        if (resp_ready[g]) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  assign busy = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      rr          <= 1'b0;
      g           <= 1'b0;
      cnt         <= '0;
      add_a       <= '0;
      add_b       <= '0;
      resp_result <= '0;
      resp_err    <= '0;
    end else begin
      if (accept) begin
        g     <= gnt;
        rr    <= ~gnt;
        add_a <= sel_a;
        add_b <= sel_b;
        if (invalid) begin
          resp_result <= QNAN;
          resp_err    <= ERR_INVALID;
        end else if (inf_any) begin
          resp_result <= inf_a ? sel_a : sel_b;
          resp_err    <= ERR_NONE;
        end
      end
      if (state == S_ISSUE) cnt <= '0;
      if (state == S_WAIT) begin
        if (add_done) begin
          resp_result <= add_result;
          resp_err    <= add_err;
        end else if (timeout_hit) begin
          resp_result <= QNAN;
          resp_err    <= ERR_INVALID;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_fp_add_arbiter.sv
// Self-checking bench for fp_add_arbiter: vector table, scoreboard queue,
// plus hand sequences for grant order, backpressure and mid-operation reset.
module tb_fp_add_arbiter;

  localparam int TO = 15;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [63:0] req_a, req_b;
  logic [1:0]  resp_valid;
  logic [1:0]  resp_ready;
  logic [31:0] resp_result;
  logic [2:0]  resp_err;
  logic        add_start;
  logic [31:0] add_a, add_b;
  logic        add_done;
  logic [31:0] add_result;
  logic [2:0]  add_err;
  logic        busy;

  fp_add_arbiter #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_result(resp_result), .resp_err(resp_err),
    .add_start(add_start), .add_a(add_a), .add_b(add_b),
    .add_done(add_done), .add_result(add_result), .add_err(add_err),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        idx;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] ares;
    logic [2:0]  aerr;
    int          dly;   // adder delay after add_start; -1 never answers
    logic [31:0] eres;
    logic [2:0]  eerr;
    logic        byp;
  } vec_t;

  typedef struct {
    logic [1:0]  vld;
    logic [31:0] res;
    logic [2:0]  err;
  } exp_t;

  vec_t vt[12];
  exp_t q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic pop_check(input string nm);
    exp_t e;
    if (q.size() == 0) begin
      check({nm, "_queue_empty"}, 1, 0);
    end else begin
      e = q.pop_front();
      check({nm, "_vld"}, resp_valid, e.vld);
      check({nm, "_res"}, resp_result, e.res);
      check({nm, "_err"}, resp_err, e.err);
    end
  endtask

  task automatic wait_ready(input string nm, output logic ok);
    int n = 0;
    @(negedge clk);
    while (req_ready == 2'b00 && n < 10) begin
      @(negedge clk);
      n++;
    end
    ok = (req_ready != 2'b00);
    if (!ok) check({nm, "_accept_timeout"}, 0, 1);
  endtask

  task automatic wait_resp(input string nm, output logic ok);
    int n = 0;
    @(negedge clk);
    while (resp_valid == 2'b00 && n < 40) begin
      @(negedge clk);
      n++;
    end
    ok = (resp_valid != 2'b00);
    if (!ok) check({nm, "_resp_timeout"}, 0, 1);
  endtask

  task automatic run_op(input int k);
    vec_t v;
    logic ok;
    int   s, r, dc, nstart, exp_r;
    v = vt[k];
    s = 0; r = 0; dc = -1; nstart = 0;
    @(posedge clk); #1;
    req_valid = 2'b00;
    req_valid[v.idx] = 1'b1;
    req_a = '0; req_b = '0;
    if (v.idx) begin req_a[63:32] = v.a; req_b[63:32] = v.b; end
    else       begin req_a[31:0]  = v.a; req_b[31:0]  = v.b; end
    wait_ready($sformatf("v%0d", k), ok);
    if (!ok) return;
    check($sformatf("v%0d_ready", k), req_ready, v.idx ? 2'b10 : 2'b01);
    q.push_back('{v.idx ? 2'b10 : 2'b01, v.eres, v.eerr});
    @(posedge clk); #1;
    req_valid = 2'b00;
    for (int c = 1; c <= 60 && r == 0; c++) begin
      @(negedge clk);
      if (c == 1) check($sformatf("v%0d_busy", k), busy, 1);
      if (add_start) begin
        nstart++;
        if (s == 0) begin
          s = c;
          check($sformatf("v%0d_add_a", k), add_a, v.a);
          check($sformatf("v%0d_add_b", k), add_b, v.b);
          if (v.dly >= 0) dc = c + v.dly;
        end
      end
      if (resp_valid != 2'b00) begin
        r = c;
        pop_check($sformatf("v%0d", k));
      end
      @(posedge clk); #1;
      add_done   = (dc == c + 1);
      add_result = v.ares;
      add_err    = v.aerr;
    end
    add_done = 1'b0;
    if (r == 0) begin
      check($sformatf("v%0d_no_resp", k), 0, 1);
      return;
    end
    check($sformatf("v%0d_nstart", k), nstart, v.byp ? 0 : 1);
    if (v.byp)         exp_r = 1;
    else if (v.dly < 0) exp_r = TO + 2;
    else               exp_r = 1 + v.dly + 1;
    check($sformatf("v%0d_latency", k), r, exp_r);
    if (v.dly < 0 && !v.byp) begin
      // Late completion after timeout must not produce anything.
      add_done = 1'b1;
      add_result = 32'h12345678;
      add_err = 3'd0;
      @(negedge clk);
      check($sformatf("v%0d_late_vld", k), resp_valid, 2'b00);
      check($sformatf("v%0d_late_busy", k), busy, 0);
      @(posedge clk); #1;
      add_done = 1'b0;
      @(negedge clk);
      check($sformatf("v%0d_late_vld2", k), resp_valid, 2'b00);
    end
  endtask

  function automatic logic [137:0] all_outs();
    return {req_ready, resp_valid, resp_result, resp_err, add_start, add_a, add_b, busy};
  endfunction

  initial begin
    logic ok;
    vt[0]  = '{1'b0, 32'h3F800000, 32'h40000000, 32'h40400000, 3'd0, 2,  32'h40400000, 3'd0, 1'b0};
    vt[1]  = '{1'b0, 32'h7F800000, 32'hFF800000, 32'h0,        3'd0, 0,  32'h7FFFFFFF, 3'd1, 1'b1};
    vt[2]  = '{1'b1, 32'h7FC00000, 32'h12345678, 32'h0,        3'd0, 0,  32'h7FFFFFFF, 3'd1, 1'b1};
    vt[3]  = '{1'b0, 32'h7F800000, 32'h3F800000, 32'h0,        3'd0, 0,  32'h7F800000, 3'd0, 1'b1};
    vt[4]  = '{1'b1, 32'h3F800000, 32'hFF800000, 32'h0,        3'd0, 0,  32'hFF800000, 3'd0, 1'b1};
    vt[5]  = '{1'b1, 32'hFF800000, 32'hFF800000, 32'h0,        3'd0, 0,  32'hFF800000, 3'd0, 1'b1};
    vt[6]  = '{1'b0, 32'h3F800000, 32'h7F800001, 32'h0,        3'd0, 0,  32'h7FFFFFFF, 3'd1, 1'b1};
    vt[7]  = '{1'b1, 32'h40000000, 32'hC0000000, 32'h00000000, 3'd0, 1,  32'h00000000, 3'd0, 1'b0};
    vt[8]  = '{1'b0, 32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000, 3'd3, 5,  32'h7F800000, 3'd3, 1'b0};
    vt[9]  = '{1'b1, 32'h3F800000, 32'h3F800000, 32'h0,        3'd0, -1, 32'h7FFFFFFF, 3'd1, 1'b0};
    vt[10] = '{1'b0, 32'h7F800000, 32'hFFFFFFFF, 32'h0,        3'd0, 0,  32'h7FFFFFFF, 3'd1, 1'b1};
    vt[11] = '{1'b1, 32'h3F800000, 32'h3F000000, 32'h41200000, 3'd5, TO, 32'h41200000, 3'd5, 1'b0};

    rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; resp_ready = 2'b11;
    add_done = 1'b0; add_result = '0; add_err = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", all_outs(), '0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Grant order with both requesters held valid from reset.
    req_valid = 2'b11;
    req_a = {32'hFF800000, 32'h7F800000};
    req_b = {32'h3F800000, 32'h3F800000};
    for (int k = 0; k < 4; k++) begin
      wait_ready($sformatf("rr%0d", k), ok);
      if (!ok) break;
      check($sformatf("rr%0d_grant", k), req_ready, (k % 2) ? 2'b10 : 2'b01);
      q.push_back('{(k % 2) ? 2'b10 : 2'b01, (k % 2) ? 32'hFF800000 : 32'h7F800000, 3'd0});
      wait_resp($sformatf("rr%0d", k), ok);
      if (!ok) break;
      pop_check($sformatf("rr%0d", k));
      check($sformatf("rr%0d_no_accept_in_resp", k), req_ready, 2'b00);
    end
    @(posedge clk); #1;
    req_valid = 2'b00;

    for (int k = 0; k < 12; k++) run_op(k);

    // Backpressure on requester 1 while requester 0 is waiting.
    @(posedge clk); #1;
    resp_ready = 2'b01;
    req_valid = 2'b10;
    req_a = {32'h7F800000, 32'h3F800000};
    req_b = {32'h40000000, 32'hFF800000};
    wait_ready("bp", ok);
    if (ok) begin
      check("bp_grant", req_ready, 2'b10);
      q.push_back('{2'b10, 32'h7F800000, 3'd0});
      @(posedge clk); #1;
      req_valid = 2'b01;
      wait_resp("bp", ok);
      if (ok) begin
        pop_check("bp");
        for (int i = 1; i < 5; i++) begin
          @(negedge clk);
          check($sformatf("bp_hold%0d_vld", i), resp_valid, 2'b10);
          check($sformatf("bp_hold%0d_res", i), resp_result, 32'h7F800000);
          check($sformatf("bp_hold%0d_noacc", i), req_ready, 2'b00);
        end
        resp_ready = 2'b11;
        @(negedge clk);
        check("bp_release_vld", resp_valid, 2'b00);
        check("bp_next_grant", req_ready, 2'b01);
        q.push_back('{2'b01, 32'hFF800000, 3'd0});
        @(posedge clk); #1;
        req_valid = 2'b00;
        wait_resp("bp_next", ok);
        if (ok) pop_check("bp_next");
      end
    end

    // Reset while waiting on the adder.
    @(posedge clk); #1;
    req_valid = 2'b01;
    req_a = {32'h0, 32'h3F800000};
    req_b = {32'h0, 32'h40000000};
    wait_ready("rstw", ok);
    @(posedge clk); #1;
    req_valid = 2'b00;
    begin
      int n = 0;
      @(negedge clk);
      while (!add_start && n < 10) begin @(negedge clk); n++; end
      check("rstw_add_start", add_start, 1);
    end
    repeat (3) @(negedge clk);
    check("rstw_busy_before", busy, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rstw_outputs", all_outs(), '0);
    @(posedge clk); #1;
    add_done = 1'b1;
    add_result = 32'h40400000;
    @(posedge clk); #1;
    add_done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("rstw_after%0d_vld", i), resp_valid, 2'b00);
      check($sformatf("rstw_after%0d_busy", i), busy, 0);
    end
    check("queue_drained", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fp_add_arbiter.md
FP_ADD_ARBITER -- requirements
Module: fp_add_arbiter

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 15: maximum cycles spent in WAIT before the operation is abandoned.
REQ-002 The block SHALL use one clock; reset is synchronous and active-high.
REQ-003 clk  in  1  rising-edge clock for all state.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 req_valid  in  2  per-requester operation request; bit i belongs to requester i.
REQ-006 req_ready  out  2  per-requester accept strobe.
REQ-007 req_a  in  64  operand A, IEEE-754 single; {req1, req0}.
REQ-008 req_b  in  64  operand B, same packing as req_a.
REQ-009 resp_valid  out  2  per-requester result valid.
REQ-010 resp_ready  in  2  per-requester result accept.
REQ-011 resp_result  out  32  result bits (sign, exponent[7:0], significand[22:0]).
REQ-012 resp_err  out  3  error code: 0 NONE, 1 INVALID, 2 DIVBYZERO, 3 OVERFLOW, 4 UNDERFLOW, 5 INEXACT.
REQ-013 add_start  out  1  one-cycle launch pulse to the shared adder.
REQ-014 add_a, add_b  out  32 each  operands driven to the adder, held stable from add_start until return to IDLE.
REQ-015 add_done  in  1  adder completion pulse.
REQ-016 add_result  in  32  adder result, valid with add_done.
REQ-017 add_err  in  3  adder error code, valid with add_done.
REQ-018 busy  out  1  high in any state other than IDLE.

Function
REQ-019 The block SHALL implement the FSM states IDLE, ISSUE, WAIT and RESP, with one operation in flight at a time.
REQ-020 IDLE, grant: with one valid, grant that requester; with both valid, grant the requester selected by the round-robin pointer rr.
REQ-021 req_ready[g] SHALL be high, combinationally, only in IDLE and only for the granted requester; operands are captured on that edge.
REQ-022 After each grant, rr SHALL point to the other requester (rr <= ~g).
REQ-023 The block SHALL classify the captured operands at acceptance: NaN = exponent 8'hFF with significand != 0; Inf = exponent 8'hFF with significand == 0.
REQ-024 If either operand is NaN, or the operands are opposite-signed Infs, the FSM SHALL go IDLE->RESP with result 32'h7FFFFFFF and err INVALID, and no add_start.
REQ-025 If exactly one operand is Inf, or both are same-signed Infs (no NaN), the FSM SHALL go IDLE->RESP with that Inf as result and err NONE, bypassing the adder.
REQ-026 All other operand pairs SHALL go IDLE->ISSUE; add_start is high for exactly the ISSUE cycle; then the FSM goes to WAIT.
REQ-027 WAIT SHALL run a timeout counter cleared on entry. On add_done, the block captures add_result and add_err and goes to RESP.
REQ-028 If TIMEOUT cycles elapse in WAIT without add_done, the block SHALL go to RESP with result 32'h7FFFFFFF and err INVALID.
REQ-029 add_done SHALL be ignored outside WAIT. If add_done arrives in the same cycle the timeout expires, add_done wins.
REQ-030 In RESP, resp_valid[g] SHALL be high and resp_result/resp_err held stable until resp_ready[g]; then the FSM goes to IDLE. resp_ready of the other requester is ignored.
REQ-031 Minimum latency SHALL be: bypass, accept at cycle N and resp_valid at N+1; adder path, add_start at N+1 and resp_valid one cycle after add_done.
REQ-032 New requests SHALL NOT be accepted in the cycle RESP completes; the earliest next accept is the following cycle.

Reset
REQ-033 On rst, the block SHALL go to IDLE and drive rr=0, req_ready=0, resp_valid=0, resp_result=0, resp_err=0, add_start=0, add_a=0, add_b=0, busy=0 and timeout counter=0.
REQ-034 Reset mid-operation SHALL drop the pending operation with no response; an add_done arriving after reset is ignored.

Verification
REQ-035 Normal add, requester 0: a=3F800000, b=40000000; adder returns 40400000/NONE 2 cycles after add_start -> add_start one cycle after accept, resp_valid[0] with 40400000, err 0.
REQ-036 Both valid from reset, then both held valid -> grant order 0,1,0,1; each resp_valid appears on the correct index only.
REQ-037 Bypass cases: a=7F800000, b=FF800000 -> 7FFFFFFF/INVALID, no add_start. a=7FC00000, b=any -> 7FFFFFFF/INVALID. a=7F800000, b=3F800000 -> 7F800000/NONE.
REQ-038 Adder never responds -> resp 7FFFFFFF/INVALID exactly TIMEOUT cycles after WAIT entry; a late add_done is ignored.
REQ-039 Backpressure: resp_ready[1] held low 5 cycles -> resp_valid[1] and resp_result stable throughout, and no new accept.
REQ-040 rst asserted during WAIT -> all outputs 0 next cycle; a subsequent add_done produces no response.
